// File: rtl/seven_seg_decoder.sv
// Decodes active-low 7-segment codes back to BCD behind a one-entry valid/ready buffer,
// keeping a shift history of decoded digits and a saturating count of illegal codes.
`timescale 1ns/1ps

module seven_seg_decoder #(
    parameter int DIGITS = 4,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    output logic [3:0]            digit_out,
    output logic                  digit_blank,
    output logic                  digit_err,
    output logic                  digit_valid,
    input  logic                  digit_ready,
    output logic [4*DIGITS-1:0]   bcd_hist,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  err_sticky
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [3:0]          digit_q;
    logic                blank_q, err_q;
    logic [4*DIGITS-1:0] hist_q, hist_d, histShift;
    logic [ERR_W-1:0]    errCnt_q, errCnt_d;
    logic                sticky_q, sticky_d;

    logic                accept;
    logic                legalDigit;
    logic [3:0]          decDigit;
    logic                decBlank, decErr;

    // A full buffer can still take a new code when the consumer drains it on the same edge.
    assign seg_ready  = (state_q == EMPTY) || digit_ready;
    assign accept     = seg_valid && seg_ready;
    assign legalDigit = accept && !decBlank && !decErr;

    always_comb begin
        decDigit = 4'hE;
        decBlank = 1'b0;
        decErr   = 1'b0;
        case (seg_in)
            7'b1000000: decDigit = 4'd0;
            7'b1111001: decDigit = 4'd1;
            7'b0100100: decDigit = 4'd2;
            7'b0110000: decDigit = 4'd3;
            7'b0011001: decDigit = 4'd4;
            7'b0010010: decDigit = 4'd5;
            7'b0000010: decDigit = 4'd6;
            7'b1111000: decDigit = 4'd7;
            7'b0000000: decDigit = 4'd8;
            7'b0010000: decDigit = 4'd9;
            7'b1111111: begin
                decDigit = 4'hF;
                decBlank = 1'b1;
            end
            default: begin
                decDigit = 4'hE;
                decErr   = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (digit_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A single-digit history has nothing to shift, so it just reloads.
    generate
        if (DIGITS == 1) begin : g_single
            assign histShift = decDigit;
        end else begin : g_multi
            assign histShift = {hist_q[4*DIGITS-5:0], decDigit};
        end
    endgenerate

    always_comb begin
        hist_d   = legalDigit ? histShift : hist_q;
        errCnt_d = errCnt_q;
        sticky_d = sticky_q;
        if (accept && decErr) begin
            sticky_d = 1'b1;
            if (errCnt_q != '1) begin
                errCnt_d = errCnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            digit_q  <= 4'h0;
            blank_q  <= 1'b0;
            err_q    <= 1'b0;
            hist_q   <= '0;
            errCnt_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            errCnt_q <= errCnt_d;
            sticky_q <= sticky_d;
            if (accept) begin
                digit_q <= decDigit;
                blank_q <= decBlank;
                err_q   <= decErr;
            end
        end
    end

    assign digit_valid = (state_q == FULL);
    assign digit_out   = digit_q;
    assign digit_blank = blank_q;
    assign digit_err   = err_q;
    assign bcd_hist    = hist_q;
    assign err_cnt     = errCnt_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: a buffer/history/error model updated every edge, a per-cycle
// comparison against it, an in-order stream scoreboard, and directed literal checks.
`timescale 1ns/1ps

module tb_seven_seg_decoder;

    localparam int DIGITS  = 4;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam logic [6:0] ILLEGAL = 7'b0101010;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [6:0]          seg_in = 7'h7F;
    logic                seg_valid = 1'b0;
    logic                seg_ready;
    logic [3:0]          digit_out;
    logic                digit_blank;
    logic                digit_err;
    logic                digit_valid;
    logic                digit_ready = 1'b0;
    logic [4*DIGITS-1:0] bcd_hist;
    logic [ERR_W-1:0]    err_cnt;
    logic                err_sticky;

    int checks = 0;
    int fails  = 0;

    bit mValid   = 1'b0;
    int mDigit   = 0;
    bit mBlank   = 1'b0;
    bit mErr     = 1'b0;
    int mHist [DIGITS];
    int mErrCnt  = 0;
    bit mSticky  = 1'b0;
    int expQ [$];
    int pushed   = 0;
    int popped   = 0;

    seven_seg_decoder #(.DIGITS(DIGITS), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst),
        .seg_in(seg_in), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .digit_out(digit_out), .digit_blank(digit_blank), .digit_err(digit_err),
        .digit_valid(digit_valid), .digit_ready(digit_ready),
        .bcd_hist(bcd_hist), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] code, input logic valid, input logic ready);
        seg_in      = code;
        seg_valid   = valid;
        digit_ready = ready;
    endtask

    // Presents a code and holds it until taken; returns just after the accepting edge.
    task automatic sendCode(input logic [6:0] code, input logic ready);
        bit acc;
        acc = 1'b0;
        applyStimulus(code, 1'b1, ready);
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = seg_ready;
            @(posedge clk);
            #1;
        end
        checkOutput("acceptTimeout", acc, 1);
    endtask

    task automatic idle(input int cycles);
        applyStimulus(seg_in, 1'b0, 1'b1);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic void refDecode(input logic [6:0] code, output int val,
                                      output bit blank, output bit err);
        val   = 14;
        blank = 1'b0;
        err   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (SEG_TABLE[i] == code) begin
                val = i;
                err = 1'b0;
            end
        end
        if (code == 7'h7F) begin
            val   = 15;
            blank = 1'b1;
            err   = 1'b0;
        end
    endfunction

    function automatic logic [4*DIGITS-1:0] histVec();
        logic [4*DIGITS-1:0] vec;
        vec = '0;
        for (int i = 0; i < DIGITS; i++) vec[4*i +: 4] = 4'(mHist[i]);
        return vec;
    endfunction

    initial begin : modelProc
        int v;
        bit b, e, rdy, acc;
        for (int i = 0; i < DIGITS; i++) mHist[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mValid  = 1'b0;
                mDigit  = 0;
                mBlank  = 1'b0;
                mErr    = 1'b0;
                mErrCnt = 0;
                mSticky = 1'b0;
                for (int i = 0; i < DIGITS; i++) mHist[i] = 0;
                pushed -= expQ.size();
                expQ.delete();
            end else begin
                rdy = !mValid || digit_ready;
                acc = seg_valid && rdy;
                if (acc) begin
                    refDecode(seg_in, v, b, e);
                    mValid = 1'b1;
                    mDigit = v;
                    mBlank = b;
                    mErr   = e;
                    if (!b && !e) begin
                        for (int i = DIGITS - 1; i > 0; i--) mHist[i] = mHist[i-1];
                        mHist[0] = v;
                    end
                    if (e) begin
                        if (mErrCnt < ERR_MAX) mErrCnt++;
                        mSticky = 1'b1;
                    end
                    expQ.push_back(v | (int'(b) << 4) | (int'(e) << 5));
                    pushed++;
                end else if (digit_ready) begin
                    mValid = 1'b0;
                end
            end
        end
    end

    // Results consumed on the coming edge must arrive in accept order, exactly once each.
    initial begin : compareProc
        forever begin
            @(negedge clk);
            checkOutput("digitValid", digit_valid, mValid);
            checkOutput("segReady", seg_ready, (!mValid || digit_ready));
            checkOutput("digitOut", digit_out, mDigit);
            checkOutput("digitBlank", digit_blank, mBlank);
            checkOutput("digitErr", digit_err, mErr);
            checkOutput("bcdHist", bcd_hist, histVec());
            checkOutput("errCnt", err_cnt, mErrCnt);
            checkOutput("errSticky", err_sticky, mSticky);
            if (digit_valid && digit_ready && !rst) begin
                checkOutput("streamPending", (expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    checkOutput("streamData", {digit_err, digit_blank, digit_out}, expQ[0]);
                    void'(expQ.pop_front());
                    popped++;
                end
            end
        end
    end

    initial begin : mainProc
        logic [6:0] code;
        int sent;
        bit pending;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resetValid", digit_valid, 0);
        checkOutput("resetReady", seg_ready, 1);
        checkOutput("resetDigit", digit_out, 0);
        checkOutput("resetHist", bcd_hist, 0);
        checkOutput("resetErrCnt", err_cnt, 0);
        checkOutput("resetSticky", err_sticky, 0);

        for (int d = 0; d < 10; d++) begin
            sendCode(SEG_TABLE[d], 1'b1);
            checkOutput("seqDigit", digit_out, d);
            checkOutput("seqValid", digit_valid, 1);
        end
        checkOutput("seqHist", bcd_hist, 16'h6789);
        checkOutput("seqErrCnt", err_cnt, 0);
        idle(2);

        sendCode(7'h7F, 1'b1);
        checkOutput("blankDigit", digit_out, 4'hF);
        checkOutput("blankFlag", digit_blank, 1);
        checkOutput("blankHist", bcd_hist, 16'h6789);
        sendCode(ILLEGAL, 1'b1);
        checkOutput("illegalDigit", digit_out, 4'hE);
        checkOutput("illegalFlag", digit_err, 1);
        checkOutput("illegalCnt", err_cnt, 1);
        checkOutput("illegalSticky", err_sticky, 1);
        checkOutput("illegalHist", bcd_hist, 16'h6789);
        idle(2);

        sendCode(SEG_TABLE[5], 1'b0);
        applyStimulus(SEG_TABLE[3], 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("holdValid", digit_valid, 1);
            checkOutput("holdDigit", digit_out, 5);
            checkOutput("holdReady", seg_ready, 0);
            @(posedge clk);
            #1;
        end
        digit_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseDigit", digit_out, 3);
        checkOutput("releaseValid", digit_valid, 1);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            sendCode(ILLEGAL, 1'b1);
            checkOutput("satDigit", digit_out, 4'hE);
        end
        checkOutput("satCnt", err_cnt, 255);
        idle(2);
        checkOutput("satHold", err_cnt, 255);

        sendCode(SEG_TABLE[7], 1'b0);
        seg_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstValid", digit_valid, 0);
        checkOutput("rstHist", bcd_hist, 0);
        checkOutput("rstErrCnt", err_cnt, 0);
        checkOutput("rstSticky", err_sticky, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendCode(SEG_TABLE[2], 1'b1);
        checkOutput("postRstDigit", digit_out, 2);
        checkOutput("postRstValid", digit_valid, 1);
        idle(2);

        sent = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 9))
                    6:       code = 7'h7F;
                    7, 8, 9: code = 7'($urandom_range(0, 127));
                    default: code = SEG_TABLE[$urandom_range(0, 9)];
                endcase
                seg_in    = code;
                seg_valid = 1'b1;
                pending   = 1'b1;
            end
            digit_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (seg_valid && seg_ready) begin
                pending = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
            if (!pending) seg_valid = 1'b0;
        end
        checkOutput("randomSent", sent, 1000);
        idle(3);
        checkOutput("drainEmpty", expQ.size(), 0);
        checkOutput("streamCount", popped, pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_decoder.md
# seven_seg_decoder

Sequential decoder that converts active-low 7-segment codes back into BCD digits. It is the inverse of the lab's BCD-to-segment encoder and sits in the self-check loopback path: the encoder output feeds this block, and its digits feed the board LEDs and a history register for comparison against the switch inputs. Input and output use valid/ready handshakes, with a one-entry output buffer. The block keeps a shift history of decoded digits and a saturating error count.

## Interface
- DIGITS, 4, number of BCD digits kept in the history register (1..8)
- ERR_W, 8, width of the saturating error counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- seg_in  in  7  segment code, active-low, bit0=a … bit6=g
- seg_valid  in  1  seg_in is valid this cycle
- seg_ready  out  1  block can accept seg_in this cycle
- digit_out  out  4  decoded BCD digit
- digit_blank  out  1  decoded code was the blank pattern
- digit_err  out  1  decoded code was not a legal pattern
- digit_valid  out  1  output buffer holds a result
- digit_ready  in  1  consumer takes the result this cycle
- bcd_hist  out  4*DIGITS  history; newest digit in [3:0]
- err_cnt  out  ERR_W  count of illegal codes, saturating
- err_sticky  out  1  set on the first illegal code, cleared only by rst

## Operation
- Legal codes:
  - 1000000 decodes to 0
  - 1111001 decodes to 1
  - 0100100 decodes to 2
  - 0110000 decodes to 3
  - 0011001 decodes to 4
  - 0010010 decodes to 5
  - 0000010 decodes to 6
  - 1111000 decodes to 7
  - 0000000 decodes to 8
  - 0010000 decodes to 9
  - 1111111 is blank: digit_out=4'hF, digit_blank=1
- Any other code is illegal: digit_out=4'hE, digit_err=1.
- Accept condition: seg_valid && seg_ready at a rising clk edge.
- Output buffer state machine, two states:
  - EMPTY to FULL on accept.
  - FULL stays FULL on accept && digit_ready. The buffer is replaced with the new result.
  - FULL to EMPTY on digit_ready && !accept.
  - EMPTY ignores digit_ready.
- seg_ready = (state==EMPTY) || digit_ready. This is combinational from digit_ready; there is no other combinational path from input to output.
- digit_valid = (state==FULL). While FULL and !digit_ready, digit_out, digit_blank and digit_err hold stable.
- History:
  - On accept of a legal digit 0–9: bcd_hist <= {bcd_hist[4*DIGITS-5:0], digit}.
  - Blank and illegal codes do not shift the history.
  - When DIGITS==1, bcd_hist simply loads the digit.
- Error count:
  - On accept of an illegal code: err_cnt increments, saturating at 2^ERR_W-1, and err_sticky <= 1.
  - History and error updates happen at accept time, independent of output backpressure.
- Reset mid-transfer: a pending buffered result is discarded and not presented after reset.

## Timing
- Reset values:
  - state=EMPTY, so digit_valid=0 and seg_ready=1
  - digit_out=4'h0, digit_blank=0, digit_err=0
  - bcd_hist=0, err_cnt=0, err_sticky=0
- Latency: accept at edge N means digit_valid=1 and the result is visible after edge N. That is 1 cycle.
- Throughput: 1 digit per cycle while digit_ready is held high.
- Backpressure:
  - When FULL and digit_ready=0, seg_ready=0 and seg_in is not sampled.
  - The producer must hold seg_in/seg_valid until accepted.
- Simultaneous accept and consume in the same cycle: the buffer is updated with no bubble cycle, and digit_valid stays 1.
- err_cnt and bcd_hist change on the same edge as the accept, one cycle before or concurrent with the consumer seeing the result.
- Asynchronous reset takes effect immediately without a clock. Release is sampled on the next clk edge.

## Test plan
- Reset, then all ten legal codes back-to-back with digit_ready=1:
  - digit_out sequence is 0..9, each one cycle after its accept.
  - After the sequence, bcd_hist=16'h6789 (DIGITS=4) and err_cnt=0.
- Blank 1111111, then illegal 0101010:
  - Blank gives digit_out=F, digit_blank=1.
  - Illegal gives digit_out=E, digit_err=1, err_cnt=1, err_sticky=1.
  - bcd_hist is unchanged by both.
- digit_ready=0 for 5 cycles after accepting code 5:
  - digit_valid=1 and digit_out=5 held.
  - seg_ready=0 and the new seg_in is not taken.
  - On digit_ready=1, the queued code 3 is accepted that edge and appears next cycle.
- 300 illegal codes: err_cnt saturates at 255 and stays there. The decoder still outputs E each time.
- rst pulse mid-stream while FULL:
  - digit_valid drops immediately, and bcd_hist and err_cnt are 0.
  - The first accept after release produces correct output one cycle later.
- Random seg_valid/digit_ready toggling over 1000 random 7-bit codes: the output stream matches a reference decode of the accepted codes in order, with no drops and no duplicates.
